exp_sched: RTL and testbench

- Round-robin scheduler that shares one exponential core among N requesters.
- Latches the granted requester's 16-bit fractional operand and sequences the core's start/done handshake.
- Returns the {intpart, fracpart} result tagged with the requester ID; a watchdog bounds the wait for done.
- Sits between client logic and the exponential unit, in the clock domain produced by FreqMult; dispatch is gated by FreqMult's valid (lock).

---
 rtl/exp_sched_pkg.sv | 15 +
 rtl/exp_sched_rr_arbiter.sv | 31 +++
 rtl/exp_sched.sv | 139 +++++++++++++
 tb/tb_exp_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exp_sched_pkg.sv
// rtl/exp_sched_pkg.sv - shared types and widths for the exponential-core scheduler
package exp_sched_pkg;

  localparam int FRAC_W = 16;
  localparam int INT_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_DONE,
    RESP
  } state_e;

endpackage

// File: rtl/exp_sched_rr_arbiter.sv
// rtl/exp_sched_rr_arbiter.sv - combinational round-robin grant starting at ptr_i
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr_i) + i) % N);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/exp_sched.sv
// rtl/exp_sched.sv - shares one exponential core among N requesters with a done watchdog
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int N          = 4,
  parameter int IDW        = $clog2(N),
  parameter int START_HOLD = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lock,
  input  logic [N-1:0]        req,
  input  logic [FRAC_W*N-1:0] x_in,
  output logic [N-1:0]        ack,
  output logic [IDW-1:0]      res_id,
  output logic [INT_W-1:0]    res_int,
  output logic [FRAC_W-1:0]   res_frac,
  output logic                res_err,
  output logic                busy,
  output logic                exp_start,
  output logic [FRAC_W-1:0]   exp_x,
  input  logic                exp_done,
  input  logic [INT_W-1:0]    exp_intpart,
  input  logic [FRAC_W-1:0]   exp_fracpart
);

  localparam int HW  = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

  state_e         state_q;
  logic [IDW-1:0] ptr_q, gid_q, ptr_d, gnt_id;
  logic [N-1:0]   gnt_oh;
  logic [HW-1:0]  hold_q;
  logic [WDW-1:0] wd_q;
  logic [FRAC_W-1:0] x_sel;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (lock && (state_q == IDLE)),
    .gnt_o (gnt_oh),
    .id_o  (gnt_id)
  );

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) x_sel = x_sel | x_in[i*FRAC_W +: FRAC_W];
    end
  end

  assign ptr_d = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      hold_q    <= '0;
      wd_q      <= '0;
      ack       <= '0;
      res_id    <= '0;
      res_int   <= '0;
      res_frac  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      exp_start <= 1'b0;
      exp_x     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt_oh) begin
            exp_x     <= x_sel;
            gid_q     <= gnt_id;
            ptr_q     <= ptr_d;
            busy      <= 1'b1;
            exp_start <= 1'b1;
            hold_q    <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (hold_q == HOLD_LAST) begin
            exp_start <= 1'b0;
            wd_q      <= '0;
            state_q   <= WAIT_LOW;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        // Ignore a done still high from the previous job until it has been seen low.
        WAIT_LOW: begin
          if (wd_q == WD_LAST) begin
            res_int      <= '0;
            res_frac     <= '0;
            res_err      <= 1'b1;
            res_id       <= gid_q;
            ack[gid_q]   <= 1'b1;
            state_q      <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (!exp_done) state_q <= WAIT_DONE;
          end
        end
        // Done is checked before the watchdog so it wins a same-cycle tie.
        WAIT_DONE: begin
          if (exp_done) begin
            res_int    <= exp_intpart;
            res_frac   <= exp_fracpart;
            res_err    <= 1'b0;
            res_id     <= gid_q;
            ack[gid_q] <= 1'b1;
            state_q    <= RESP;
          end else if (wd_q == WD_LAST) begin
            res_int    <= '0;
            res_frac   <= '0;
            res_err    <= 1'b1;
            res_id     <= gid_q;
            ack[gid_q] <= 1'b1;
            state_q    <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          ack     <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sched.sv
// tb/tb_exp_sched.sv - directed self-checking bench for exp_sched with a behavioural core
module tb_exp_sched;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, lock;
  logic [3:0]  req;
  logic [63:0] x_in;
  logic [3:0]  ack;
  logic [1:0]  res_id, res_int, exp_intpart;
  logic [15:0] res_frac, exp_x, exp_fracpart;
  logic        res_err, busy, exp_start, exp_done;

  int total = 0;
  int bad   = 0;

  logic [15:0] xs [4];

  bit core_hang  = 1'b0;
  bit stale_arm  = 1'b0;
  int core_delay = 20;

  typedef struct {
    logic [3:0] req;
    int         id;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  exp_sched #(.N(N), .IDW(2), .START_HOLD(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .lock(lock), .req(req), .x_in(x_in),
    .ack(ack), .res_id(res_id), .res_int(res_int), .res_frac(res_frac),
    .res_err(res_err), .busy(busy), .exp_start(exp_start), .exp_x(exp_x),
    .exp_done(exp_done), .exp_intpart(exp_intpart), .exp_fracpart(exp_fracpart)
  );

  function automatic logic [17:0] ref_exp(input logic [15:0] x);
    case (x)
      16'h0000: return {2'd1, 16'h0000};
      16'h4000: return {2'd1, 16'h48B5};
      16'h8000: return {2'd1, 16'hA612};
      16'hC000: return {2'd2, 16'h1DF3};
      default:  return {2'd0, x};
    endcase
  endfunction

  // Core model: done is a level that drops at the next start unless a stale hold is armed.
  initial begin
    bit prev_start = 1'b0;
    bit started    = 1'b0;
    int cnt        = 0;
    int stale_left = 0;
    exp_done     = 1'b0;
    exp_intpart  = '0;
    exp_fracpart = '0;
    forever begin
      @(negedge clk);
      if (exp_start && !prev_start) begin
        started = 1'b1;
        cnt     = 0;
        if (stale_arm) begin
          stale_left = 10;
          stale_arm  = 1'b0;
        end else begin
          exp_done = 1'b0;
        end
      end
      prev_start = exp_start;
      if (stale_left > 0) begin
        stale_left--;
        if (stale_left == 0) exp_done = 1'b0;
      end
      if (started && !exp_start) begin
        cnt++;
        if (cnt >= core_delay && !core_hang) begin
          {exp_intpart, exp_fracpart} = ref_exp(exp_x);
          exp_done = 1'b1;
          started  = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_ack"},      32'(ack),       0);
    chk({pfx, "_res_id"},   32'(res_id),    0);
    chk({pfx, "_res_int"},  32'(res_int),   0);
    chk({pfx, "_res_frac"}, 32'(res_frac),  0);
    chk({pfx, "_res_err"},  32'(res_err),   0);
    chk({pfx, "_busy"},     32'(busy),      0);
    chk({pfx, "_start"},    32'(exp_start), 0);
    chk({pfx, "_exp_x"},    32'(exp_x),     0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_job(input int id, input bit err, output int first_busy);
    int          starts = 0;
    bit          seen   = 1'b0;
    logic [17:0] want;
    first_busy = -1;
    want = err ? 18'd0 : ref_exp(xs[id]);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (busy && first_busy < 0) begin
        first_busy = c;
        chk($sformatf("exp_x_id%0d", id), 32'(exp_x), 32'(xs[id]));
      end
      if (exp_start) starts++;
      if (ack != 0) begin
        seen = 1'b1;
        chk($sformatf("ack_id%0d", id),    32'(ack),      32'(4'b0001 << id));
        chk($sformatf("res_id%0d", id),    32'(res_id),   32'(id));
        chk($sformatf("res_int_id%0d", id),  32'(res_int),  32'(want[17:16]));
        chk($sformatf("res_frac_id%0d", id), 32'(res_frac), 32'(want[15:0]));
        chk($sformatf("res_err_id%0d", id),  32'(res_err),  32'(err));
        chk($sformatf("start_len_id%0d", id), 32'(starts), 32'd4);
      end
    end
    chk($sformatf("ack_seen_id%0d", id), 32'(seen), 32'd1);
    @(negedge clk);
    chk($sformatf("ack_pulse_id%0d", id), 32'(ack),  32'd0);
    chk($sformatf("busy_drop_id%0d", id), 32'(busy), 32'd0);
  endtask

  initial begin
    int fb;
    int viol;
    xs[0] = 16'h8000; xs[1] = 16'h4000; xs[2] = 16'hC000; xs[3] = 16'h0000;
    x_in = {xs[3], xs[2], xs[1], xs[0]};
    tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3}; tbl[4] = '{4'b1111, 0}; tbl[5] = '{4'b1010, 1};
    tbl[6] = '{4'b1010, 3}; tbl[7] = '{4'b0001, 0}; tbl[8] = '{4'b0110, 1};
    tbl[9] = '{4'b0110, 2};
    rst = 1'b0; lock = 1'b0; req = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b1;

    lock = 1'b1;
    req  = 4'b0001;
    run_job(0, 1'b0, fb);
    req = '0;

    do_reset();
    for (int k = 0; k < 10; k++) begin
      req = tbl[k].req;
      run_job(tbl[k].id, 1'b0, fb);
    end
    req = '0;

    lock = 1'b0;
    req  = 4'b0100;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (exp_start || busy) viol++;
    end
    chk("lock_gate", 32'(viol), 0);
    lock = 1'b1;
    run_job(2, 1'b0, fb);
    chk("lock_grant_lat", 32'(fb), 0);
    req = '0;

    core_hang = 1'b1;
    req = 4'b0001;
    run_job(0, 1'b1, fb);
    core_hang = 1'b0;
    req = 4'b1000;
    run_job(3, 1'b0, fb);

    stale_arm = 1'b1;
    req = 4'b0010;
    run_job(1, 1'b0, fb);
    req = '0;

    req = 4'b0100;
    fb = 0;
    for (int c = 0; c < 100 && fb < 10; c++) begin
      @(negedge clk);
      if (busy && !exp_start) fb++;
    end
    chk("midjob_reached", 32'(fb), 10);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midjob_rst");
    viol = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != 0 || busy) viol++;
    end
    chk("midjob_no_ack", 32'(viol), 0);
    rst = 1'b1;
    req = 4'b1010;
    run_job(1, 1'b0, fb);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
